// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, with a start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add a `sub` port that selects a - b (two's complement).

module half_adder (
    input  logic x_i,
    input  logic y_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = x_i ^ y_i;
    assign c_o = x_i & y_i;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_sh_q;
    logic [WIDTH-1:0]  b_sh_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  acc_d;
    logic [WIDTH-1:0]  sum_q;
    logic [CW-1:0]     bit_cnt_q;
    logic              c_q;
    logic              carry_out_q;
    logic              busy_q;
    logic              done_q;

    logic              s_lo;
    logic              c_lo;
    logic              s_bit;
    logic              c_hi;
    logic              c_next;
    logic [WIDTH-1:0]  b_load;
    logic              c_load;

    // One full-add slice: two half adders, carries merged with an OR.
    half_adder u_ha_lo (.x_i(a_sh_q[0]), .y_i(b_sh_q[0]), .s_o(s_lo),  .c_o(c_lo));
    half_adder u_ha_hi (.x_i(s_lo),      .y_i(c_q),       .s_o(s_bit), .c_o(c_hi));

    assign c_next = c_lo | c_hi;
    assign acc_d  = {s_bit, acc_q[WIDTH-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
    assign b_load = sub ? ~b : b;
    assign c_load = sub;
`else
    assign b_load = b;
    assign c_load = 1'b0;
`endif

    // NOTE: all state, including the datapath shift registers, uses non-blocking
    // assignments and is cleared by reset so an aborted add leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            bit_cnt_q   <= '0;
            c_q         <= 1'b0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        a_sh_q    <= a;
                        b_sh_q    <= b_load;
                        c_q       <= c_load;
                        bit_cnt_q <= '0;
                        acc_q     <= '0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q     <= acc_d;
                    c_q       <= c_next;
                    a_sh_q    <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q    <= {1'b0, b_sh_q[WIDTH-1:1]};
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        sum_q       <= acc_d;
                        carry_out_q <= c_next;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8), including the
// subtract vectors when SERIAL_ADDER_SUB_EN is defined.

module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; sample/drive 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        a     = av;
        b     = bv;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = sv;
`else
        if (sv) $display("note: subtract requested without SERIAL_ADDER_SUB_EN");
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cycles++;
            tick();
            edges++;
            if (busy && done) overlap++;
        end
        check({tag, "_done_seen"}, done, 1);
    endtask

    int edges;
    int busy_cycles;
    int done_seen;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", carry_out, 0);
        rst = 1'b0;
        tick();

        // 0x5A + 0x33: timing and basic add
        start_op(8'h5A, 8'h33, 1'b0);
        check("t1_busy_after_start", busy, 1);
        check("t1_sum_held", sum, 8'h00);
        wait_done("t1", edges, busy_cycles);
        check("t1_latency", edges, 8);
        check("t1_busy_cycles", busy_cycles, 8);
        check("t1_busy_in_done", busy, 0);
        check("t1_sum", sum, 8'h8D);
        check("t1_cout", carry_out, 0);
        tick();
        check("t1_done_pulse", done, 0);
        check("t1_idle_busy", busy, 0);

        // 0xFF + 0x01 then back-to-back 0xFF + 0xFF
        start_op(8'hFF, 8'h01, 1'b0);
        check("t2_sum_held_in_run", sum, 8'h8D);
        wait_done("t2a", edges, busy_cycles);
        check("t2a_sum", sum, 8'h00);
        check("t2a_cout", carry_out, 1);
        start_op(8'hFF, 8'hFF, 1'b0);
        check("t2b_busy", busy, 1);
        check("t2b_done_low", done, 0);
        check("t2b_sum_held", sum, 8'h00);
        wait_done("t2b", edges, busy_cycles);
        check("t2b_latency", edges, 8);
        check("t2b_sum", sum, 8'hFE);
        check("t2b_cout", carry_out, 1);
        tick();

        // 0x12 + 0x34 with a start pulse and new operands mid-RUN
        start_op(8'h12, 8'h34, 1'b0);
        tick();
        tick();
        tick();
        start_op(8'hFF, 8'hFF, 1'b0);
        check("t3_busy_mid", busy, 1);
        wait_done("t3", edges, busy_cycles);
        check("t3_latency_rest", edges, 4);
        check("t3_sum", sum, 8'h46);
        check("t3_cout", carry_out, 0);
        tick();
        check("t3_back_idle", busy, 0);

        // 0x80 + 0x80 aborted by reset at bit 4
        start_op(8'h80, 8'h80, 1'b0);
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_rst_busy", busy, 0);
        check("t4_rst_done", done, 0);
        check("t4_rst_sum", sum, 8'h00);
        check("t4_rst_cout", carry_out, 0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) done_seen++;
        end
        check("t4_no_done_after_abort", done_seen, 0);
        start_op(8'h01, 8'h02, 1'b0);
        wait_done("t4b", edges, busy_cycles);
        check("t4b_sum", sum, 8'h03);
        check("t4b_cout", carry_out, 0);
        tick();

`ifdef SERIAL_ADDER_SUB_EN
        start_op(8'h10, 8'h01, 1'b1);
        wait_done("s1", edges, busy_cycles);
        check("s1_sum", sum, 8'h0F);
        check("s1_cout", carry_out, 1);
        tick();
        start_op(8'h01, 8'h02, 1'b1);
        wait_done("s2", edges, busy_cycles);
        check("s2_sum", sum, 8'hFF);
        check("s2_cout", carry_out, 0);
        tick();
        start_op(8'h5A, 8'h33, 1'b0);
        wait_done("s3", edges, busy_cycles);
        check("s3_add_sum", sum, 8'h8D);
        tick();
`endif

        check("busy_done_overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
